// File: rtl/adder_stage_pkg.sv
// Shared types for the adder result stage: FSM states, flag bit positions
// and the {sum, flags} result record held in the main and skid registers.
package adder_stage_pkg;

  localparam int RESULT_W = 32;
  localparam int FLAG_W   = 4;

  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef struct packed {
    logic [RESULT_W-1:0] sum;
    flags_t              flags;
  } result_t;

  function automatic result_t pack_result(input logic [RESULT_W-1:0] sum,
                                          input flags_t flags);
    result_t r;
    r.sum   = sum;
    r.flags = flags;
    return r;
  endfunction

endpackage

// File: rtl/adder_flag_gen.sv
// Combinational N/Z/C/V status generation from the adder operands and result.
module adder_flag_gen
  import adder_stage_pkg::*;
#(
  parameter int WIDTH = RESULT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output flags_t           flags
);

  // Signed overflow: operands agree in sign but the result does not.
  assign flags[FLG_N] = sum[WIDTH-1];
  assign flags[FLG_Z] = (sum == '0);
  assign flags[FLG_C] = cout;
  assign flags[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/adder_result_stage.sv
// Two-entry skid buffer capturing the adder result and its flags.
// Optional STICKY_FLAGS_EN adds sticky carry/overflow accumulation.
module adder_result_stage
  import adder_stage_pkg::*;
#(
  parameter int WIDTH = RESULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [FLAG_W-1:0] out_flags
`ifdef STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_cv
`endif
);

  state_t  state;
  result_t main_reg;
  result_t skid_reg;
  result_t new_result;
  flags_t  new_flags;
  logic    in_ready_reg;
  logic    in_xfer;
  logic    out_xfer;

  adder_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .a     (in_a),
    .b     (in_b),
    .sum   (in_sum),
    .cout  (in_cout),
    .flags (new_flags)
  );

  assign new_result = pack_result(in_sum, new_flags);
  assign in_xfer    = in_valid && in_ready_reg;
  assign out_valid  = (state != ST_EMPTY);
  assign out_xfer   = out_valid && out_ready;

  // in_ready is a flop so it stays low through reset and rises one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          in_ready_reg <= 1'b1;
          if (in_xfer) begin
            main_reg <= new_result;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          in_ready_reg <= 1'b1;
          if (in_xfer && !out_xfer) begin
            skid_reg     <= new_result;
            state        <= ST_TWO;
            in_ready_reg <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state <= ST_EMPTY;
          end else if (in_xfer && out_xfer) begin
            main_reg <= new_result;
          end
        end
        ST_TWO: begin
          in_ready_reg <= 1'b0;
          if (out_xfer) begin
            main_reg     <= skid_reg;
            state        <= ST_ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state        <= ST_EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_sum   = main_reg.sum;
  assign out_flags = main_reg.flags;

`ifdef STICKY_FLAGS_EN
  logic [1:0] sticky_reg;
  logic [1:0] xfer_cv;

  assign xfer_cv = {main_reg.flags[FLG_C], main_reg.flags[FLG_V]};

  // A clear in the same cycle as a transfer keeps only that transfer's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_reg <= 2'b00;
    end else if (sticky_clr) begin
      sticky_reg <= out_xfer ? xfer_cv : 2'b00;
    end else if (out_xfer) begin
      sticky_reg <= sticky_reg | xfer_cv;
    end
  end

  assign sticky_cv = sticky_reg;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage; the sticky-flag tests run
// only when STICKY_FLAGS_EN is defined.
module tb_adder_result_stage;
  import adder_stage_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_sum;
  logic         in_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [3:0]   out_flags;
`ifdef STICKY_FLAGS_EN
  logic         sticky_clr;
  logic [1:0]   sticky_cv;
`endif

  int checks = 0;
  int passes = 0;

  adder_result_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags)
`ifdef STICKY_FLAGS_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_cv  (sticky_cv)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] s, input logic c);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sum   = s;
    in_cout  = c;
  endtask

  function automatic logic [3:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] s, input logic c);
    logic [3:0] f;
    f[3] = s[W-1];
    f[2] = (s == 0);
    f[1] = c;
    f[0] = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return f;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q_sum[$];
    logic [3:0]   q_flg[$];
    logic [W-1:0] ra, rb, rs;
    logic         rc;
    logic         in_fire, out_fire;
    int           beats, cyc;

    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'h5, 32'h6, 32'hB, 1'b0);
`ifdef STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    // Reset with in_valid high
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_no_accept", out_valid, 0);

    // Overflow then carry/zero, back to back
    out_ready = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    step();
    check("ovf_valid", out_valid, 1);
    check("ovf_sum", out_sum, 32'h8000_0000);
    check("ovf_flags", out_flags, 4'b1001);
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    step();
    check("zc_sum", out_sum, 0);
    check("zc_flags", out_flags, 4'b0110);
    drive(1'b0, 0, 0, 0, 1'b0);
    step();
    check("zc_drained", out_valid, 0);

    // Stall: beats 1, 2, 3 with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 0, 0, 32'd1, 1'b0);
    step();
    check("stall_b1_out", out_sum, 1);
    check("stall_b1_ready", in_ready, 1);
    drive(1'b1, 0, 0, 32'd2, 1'b0);
    step();
    check("stall_full_ready", in_ready, 0);
    check("stall_hold1", out_sum, 1);
    drive(1'b1, 0, 0, 32'd3, 1'b0);
    step();
    check("stall_b3_blocked", in_ready, 0);
    check("stall_hold2", out_sum, 1);
    check("stall_hold_flags", out_flags, 4'b0000);
    out_ready = 1'b1;
    step();
    check("stall_out2", out_sum, 2);
    check("stall_reopen", in_ready, 1);
    step();
    check("stall_out3", out_sum, 3);
    drive(1'b0, 0, 0, 0, 1'b0);
    step();
    check("stall_drained", out_valid, 0);

    // Full-rate streaming
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'd100, 32'd0, 32'd100 + i, 1'b0);
      step();
      check("stream_ready", in_ready, 1);
      check("stream_sum", out_sum, 32'd100 + i);
    end
    drive(1'b0, 0, 0, 0, 1'b0);
    step();

    // Random handshake with scoreboard
    beats = 0;
    cyc = 0;
    while (beats < 10000 && cyc < 60000) begin
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? (~ra + 1) : $urandom();
      {rc, rs} = {1'b0, ra} + {1'b0, rb};
      drive($urandom_range(0, 3) != 0, ra, rb, rs, rc);
      out_ready = ($urandom_range(0, 3) != 0);
      in_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (q_sum.size() == 0) begin
          check("rand_spurious", 1, 0);
        end else begin
          check("rand_beat", {out_sum, out_flags}, {q_sum.pop_front(), q_flg.pop_front()});
          beats++;
        end
      end
      if (in_fire) begin
        q_sum.push_back(rs);
        q_flg.push_back(model_flags(ra, rb, rs, rc));
      end
      step();
      cyc++;
    end
    check("rand_beats", beats, 10000);
    drive(1'b0, 0, 0, 0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) begin
        if (q_sum.size() == 0) check("drain_spurious", 1, 0);
        else check("drain_beat", {out_sum, out_flags}, {q_sum.pop_front(), q_flg.pop_front()});
      end
      step();
    end
    check("rand_queue_empty", q_sum.size(), 0);
    check("rand_out_idle", out_valid, 0);

    // Reset mid-operation discards both entries
    out_ready = 1'b0;
    drive(1'b1, 0, 0, 32'd7, 1'b0);
    step();
    step();
    check("mid_full", in_ready, 0);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_sum", out_sum, 0);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    step();
    check("mid_post_ready", in_ready, 1);
    check("mid_post_valid", out_valid, 0);

`ifdef STICKY_FLAGS_EN
    check("sticky_rst", sticky_cv, 2'b00);
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd1, 32'd1, 32'd2, 1'b0);
      step();
    end
    drive(1'b0, 0, 0, 0, 1'b0);
    step();
    step();
    check("sticky_v_held", sticky_cv, 2'b01);
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
    step();
    drive(1'b0, 0, 0, 0, 1'b0);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("sticky_clr_xfer", sticky_cv, 2'b10);
    step();
    check("sticky_c_held", sticky_cv, 2'b10);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
